axi_lite_cmd_master: RTL and testbench

// - Single-outstanding AXI4-Lite initiator; turns a simple command/response

---
 rtl/axi_lite_cmd_master_if.sv | 40 ++++
 rtl/axi_lite_cmd_master.sv | 219 +++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and its responder.
// The master modport is the initiator side; the slave modport is the responder side.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic [1:0]              bresp;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic [1:0]              rresp;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bvalid, bresp, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rvalid, rresp, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bvalid, bresp, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rvalid, rresp, input rready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a cmd/rsp handshake.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  axi_lite_cmd_master_if.master   axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                  state_reg;
  logic                    cmd_ready_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH/8-1:0] wstrb_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    aw_done_reg;
  logic                    w_done_reg;
  logic                    bready_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic                    rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [1:0]              rsp_resp_reg;
  logic                    rsp_timeout_reg;

  logic aw_fire;
  logic w_fire;
  logic ar_fire;
  logic busy;
  logic step_done;
  logic timeout_hit;

  assign aw_fire = awvalid_reg && axi.awready;
  assign w_fire  = wvalid_reg && axi.wready;
  assign ar_fire = arvalid_reg && axi.arready;
  assign busy    = (state_reg == WR) || (state_reg == WR_RESP) ||
                   (state_reg == RD_ADDR) || (state_reg == RD_DATA);

  // Current state's exit handshake; a real handshake beats the watchdog.
  always_comb begin
    step_done = 1'b0;
    case (state_reg)
      WR:      step_done = (aw_done_reg || aw_fire) && (w_done_reg || w_fire);
      WR_RESP: step_done = axi.bvalid;
      RD_ADDR: step_done = ar_fire;
      RD_DATA: step_done = axi.rvalid;
      default: step_done = 1'b0;
    endcase
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer_reg;

  assign timeout_hit = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_reg <= '0;
    end else if (state_reg == IDLE) begin
      timer_reg <= '0;
    end else if (busy) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cmd_ready_reg   <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= 2'b00;
      rsp_timeout_reg <= 1'b0;
    end else if (busy && timeout_hit && !step_done) begin
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      bready_reg      <= 1'b0;
      rready_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b1;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= 2'b10;
      rsp_timeout_reg <= 1'b1;
      state_reg       <= RSP;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_ready_reg && cmd_valid) begin
            cmd_ready_reg <= 1'b0;
            addr_reg      <= cmd_addr;
            wdata_reg     <= cmd_wdata;
            wstrb_reg     <= cmd_wstrb;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            if (cmd_write) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_ADDR;
            end
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end
        WR: begin
          if (aw_fire) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_fire) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if (step_done) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            bready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= axi.bresp;
            rsp_timeout_reg <= 1'b0;
            state_reg       <= RSP;
          end
        end
        RD_ADDR: begin
          if (ar_fire) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            rready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= axi.rdata;
            rsp_resp_reg    <= axi.rresp;
            rsp_timeout_reg <= 1'b0;
            state_reg       <= RSP;
          end
        end
        RSP: begin
          // cmd_ready rises together with the return to IDLE, one cycle after rsp_ready.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_resp    = rsp_resp_reg;
  assign rsp_timeout = rsp_timeout_reg;

  assign axi.awaddr  = addr_reg;
  assign axi.awvalid = awvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = wstrb_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.bready  = bready_reg;
  assign axi.araddr  = addr_reg;
  assign axi.arvalid = arvalid_reg;
  assign axi.rready  = rready_reg;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a delay-programmable AXI4-Lite responder.
// The watchdog case runs only when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axi(bus)
  );

  // Responder: per-channel ready delays, B one cycle after both AW and W, R after r_delay.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt, b_beats;
  logic        aw_got, w_got, r_pend, rd_win;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_delay);
  assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
  assign bus.bresp   = s_bresp;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_beats <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; rd_win <= 1'b0;
      bus.bvalid <= 1'b0; bus.rvalid <= 1'b0;
      last_awaddr <= '0; last_wdata <= '0; last_araddr <= '0; last_wstrb <= '0;
    end else begin
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
      if (bus.awvalid && bus.awready) last_awaddr <= bus.awaddr;
      if (bus.wvalid && bus.wready) begin
        last_wdata <= bus.wdata;
        last_wstrb <= bus.wstrb;
      end
      if ((aw_got || (bus.awvalid && bus.awready)) && (w_got || (bus.wvalid && bus.wready))
          && !bus.bvalid) begin
        bus.bvalid <= 1'b1;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else begin
        aw_got <= aw_got || (bus.awvalid && bus.awready);
        w_got  <= w_got || (bus.wvalid && bus.wready);
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
        b_beats    <= b_beats + 1;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        last_araddr <= bus.araddr;
        rd_win      <= 1'b1;
        if (r_delay == 0) bus.rvalid <= 1'b1;
        else begin
          r_pend <= 1'b1;
          r_cnt  <= r_delay - 1;
        end
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          bus.rvalid <= 1'b1;
          r_pend     <= 1'b0;
        end else r_cnt <= r_cnt - 1;
      end
      if (bus.rvalid && bus.rready) rd_win <= 1'b0;
    end
  end

  // Bus observer sampling on the falling edge.
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, rise_skew = 0, aw_unstable = 0, rready_bad = 0;
  logic        aw_prev = 1'b0, w_prev = 1'b0;
  logic [31:0] awaddr_prev = '0;

  always @(negedge clk) begin
    if (bus.awvalid) aw_hi <= aw_hi + 1;
    if (bus.wvalid) w_hi <= w_hi + 1;
    if (bus.arvalid) ar_hi <= ar_hi + 1;
    if ((bus.awvalid && !aw_prev) != (bus.wvalid && !w_prev)) rise_skew <= rise_skew + 1;
    if (bus.awvalid && aw_prev && (bus.awaddr != awaddr_prev)) aw_unstable <= aw_unstable + 1;
    if (bus.rready && !rd_win) rready_bad <= rready_bad + 1;
    aw_prev     <= bus.awvalid;
    w_prev      <= bus.wvalid;
    awaddr_prev <= bus.awaddr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command from acceptance through response; hold = cycles rsp_ready stays low.
  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                         input logic exp_tmo, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check({tag, "_accept_bound"}, 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 400);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check({tag, "_resp"}, 64'(rsp_resp), 64'(exp_resp));
    check({tag, "_timeout"}, 64'(rsp_timeout), 64'(exp_tmo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
      check({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
      check({tag, "_hold_no_req"}, 64'(bus.awvalid | bus.arvalid), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
    $display("txn %s: wr=%0d addr=0x%0h rdata=0x%0h resp=%0d tmo=%0d lat=%0d",
             tag, wr, addr, rsp_rdata, rsp_resp, rsp_timeout, lat);
  endtask

  initial begin
    int s_aw, s_w, s_ar, s_skew, s_unst, s_b, s_rbad;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}), 64'd0);
    check("rst_readies", 64'({bus.bready, bus.rready}), 64'd0);
    check("rst_awaddr", 64'(bus.awaddr), 64'd0);
    check("rst_rsp", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
    rst = 1'b0;

    // Zero-wait write.
    s_skew = rise_skew; s_b = b_beats;
    run_cmd("wr_zero_wait", 1'b1, 32'h3, 32'h83, 4'h1, 0, 32'h0, 2'b00, 1'b0, 3);
    check("wr_zero_wait_skew", 64'(rise_skew - s_skew), 64'd0);
    check("wr_zero_wait_awaddr", 64'(last_awaddr), 64'h3);
    check("wr_zero_wait_wdata", 64'(last_wdata), 64'h83);
    check("wr_zero_wait_wstrb", 64'(last_wstrb), 64'h1);
    check("wr_zero_wait_bbeats", 64'(b_beats - s_b), 64'd1);

    // AW delayed 3 cycles, W immediate, SLVERR passed through.
    aw_delay = 3; s_bresp = 2'b10;
    s_aw = aw_hi; s_w = w_hi; s_unst = aw_unstable; s_b = b_beats; s_skew = rise_skew;
    run_cmd("wr_aw_slow", 1'b1, 32'h10, 32'h1234_5678, 4'hF, 0, 32'h0, 2'b10, 1'b0, 6);
    check("wr_aw_slow_aw_cycles", 64'(aw_hi - s_aw), 64'd4);
    check("wr_aw_slow_w_cycles", 64'(w_hi - s_w), 64'd1);
    check("wr_aw_slow_addr_stable", 64'(aw_unstable - s_unst), 64'd0);
    check("wr_aw_slow_bbeats", 64'(b_beats - s_b), 64'd1);
    check("wr_aw_slow_skew", 64'(rise_skew - s_skew), 64'd0);
    check("wr_aw_slow_awaddr", 64'(last_awaddr), 64'h10);
    aw_delay = 0; s_bresp = 2'b00;

    // Read with two R wait cycles, response held off for 5 cycles.
    r_delay = 2; s_rdata = 32'h60;
    s_ar = ar_hi; s_rbad = rready_bad;
    run_cmd("rd_wait", 1'b0, 32'h5, 32'h0, 4'h0, 5, 32'h60, 2'b00, 1'b0, 5);
    check("rd_wait_ar_cycles", 64'(ar_hi - s_ar), 64'd1);
    check("rd_wait_rready_window", 64'(rready_bad - s_rbad), 64'd0);
    check("rd_wait_araddr", 64'(last_araddr), 64'h5);
    r_delay = 0;

    // Zero-wait read with EXOKAY.
    s_rdata = 32'hA5A5_1234; s_rresp = 2'b01;
    run_cmd("rd_zero_wait", 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'hA5A5_1234, 2'b01, 1'b0, 3);
    s_rresp = 2'b00;

    // Reset while awvalid is high.
    aw_delay = 10;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hDEAD; cmd_wstrb = 4'h3;
    begin
      int n = 0;
      while (!cmd_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_awvalid_before", 64'(bus.awvalid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}), 64'd0);
    check("rst_mid_readies", 64'({bus.bready, bus.rready, cmd_ready}), 64'd0);
    $display("txn rst_mid: awvalid=%0d wvalid=%0d", bus.awvalid, bus.wvalid);
    @(negedge clk);
    rst = 1'b0;
    aw_delay = 0;
    run_cmd("wr_after_rst", 1'b1, 32'h3, 32'h83, 4'h1, 0, 32'h0, 2'b00, 1'b0, 3);
    check("wr_after_rst_awaddr", 64'(last_awaddr), 64'h3);

`ifdef AXI_MASTER_TIMEOUT_EN
    // Responder never raises arready; watchdog limit is 16.
    ar_delay = 1000;
    s_ar = ar_hi;
    run_cmd("rd_timeout", 1'b0, 32'h7, 32'h0, 4'h0, 0, 32'h0, 2'b10, 1'b1, 17);
    check("rd_timeout_ar_cycles", 64'(ar_hi - s_ar), 64'd16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ar_delay = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout, expected completion");
    $fatal(1, "time limit");
  end
endmodule
